// File: rtl/alu_sat_flag_stage.sv
// Result/flag stage behind the chained CLA adder slices: saturates the raw sum
// per operation mode, registers it behind a valid/ready handshake and keeps N/Z/V.
module alu_sat_flag_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [3:0]       in_nib_ovfl,
  input  logic [1:0]       in_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam logic [1:0] MODE_ADD    = 2'b00;
  localparam logic [1:0] MODE_SUB    = 2'b01;
  localparam logic [1:0] MODE_PADDSB = 2'b10;
  localparam logic [1:0] MODE_PASS   = 2'b11;

  // A wrapped sum has the wrong sign, so its MSB selects the opposite rail.
  function automatic logic [WIDTH-1:0] sat_word(input logic [WIDTH-1:0] sum,
                                                input logic              ovfl);
    logic [WIDTH-1:0] res;
    if (ovfl) begin
      res = sum[WIDTH-1] ? 16'h7FFF : 16'h8000;
    end else begin
      res = sum;
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] sat_nibbles(input logic [WIDTH-1:0] sum,
                                                   input logic [3:0]       ovfl);
    logic [WIDTH-1:0] res;
    res = sum;
    for (int i = 0; i < 4; i++) begin
      if (ovfl[i]) begin
        res[4*i +: 4] = sum[4*i+3] ? 4'h7 : 4'h8;
      end else begin
        res[4*i +: 4] = sum[4*i +: 4];
      end
    end
    return res;
  endfunction

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic [WIDTH-1:0] sat_res_s;
  logic             accept_s;
  logic             consume_s;

  assign in_ready  = ~valid_q | out_ready;
  assign accept_s  = in_valid & in_ready & ~flush;
  assign consume_s = valid_q & out_ready;

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign flag_n    = n_q;
  assign flag_z    = z_q;
  assign flag_v    = v_q;

  always_comb begin
    sat_res_s = in_sum;
    case (in_mode)
      MODE_ADD, MODE_SUB: sat_res_s = sat_word(in_sum, in_nib_ovfl[3]);
      MODE_PADDSB:        sat_res_s = sat_nibbles(in_sum, in_nib_ovfl);
      MODE_PASS:          sat_res_s = in_sum;
      default:            sat_res_s = in_sum;
    endcase
  end

  // Flush wins over accept/consume; flags only move on an accepted op.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    n_d     = n_q;
    z_d     = z_q;
    v_d     = v_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      data_d  = sat_res_s;
      case (in_mode)
        MODE_ADD, MODE_SUB: begin
          n_d = sat_res_s[WIDTH-1];
          z_d = (sat_res_s == '0);
          v_d = in_nib_ovfl[3];
        end
        MODE_PASS: begin
          z_d = (sat_res_s == '0);
        end
        MODE_PADDSB: begin
          z_d = z_q;
        end
        default: begin
          z_d = z_q;
        end
      endcase
    end else if (consume_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      n_q     <= n_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: tb/tb_alu_sat_flag_stage.sv
// Self-checking bench for alu_sat_flag_stage: directed vector table, hand-written
// handshake sequences and a randomized run against a queue-based reference model.
module tb_alu_sat_flag_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic [3:0]  in_nib_ovfl;
  logic [1:0]  in_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        flag_n, flag_z, flag_v;

  int tests = 0;
  int fails = 0;

  logic [15:0] mq[$];
  logic [15:0] m_data;
  logic        m_n, m_z, m_v;

  always #5 clk = ~clk;

  alu_sat_flag_stage #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_nib_ovfl(in_nib_ovfl), .in_mode(in_mode),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_sat(input logic [15:0] s, input logic [3:0] o,
                                          input logic [1:0] m);
    logic [15:0] r;
    int nib;
    r = s;
    if (m == 2'd0 || m == 2'd1) begin
      if (o[3]) r = s[15] ? 16'h7FFF : 16'h8000;
    end else if (m == 2'd2) begin
      for (int i = 0; i < 4; i++) begin
        nib = int'((s >> (4*i)) & 16'h000F);
        if (o[i]) nib = (nib >= 8) ? 7 : 8;
        r[4*i +: 4] = 4'(nib);
      end
    end
    return r;
  endfunction

  // One clock: predict from the driven inputs, then compare after the edge.
  task automatic tick();
    logic [15:0] res;
    logic        exp_ready;
    #1;
    exp_ready = (mq.size() == 0) || out_ready;
    if (!rst) chk("in_ready", {15'd0, in_ready}, {15'd0, exp_ready});
    res = ref_sat(in_sum, in_nib_ovfl, in_mode);
    if (rst) begin
      mq.delete();
      m_data = 16'h0000;
      m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (in_valid && exp_ready) begin
        mq.push_back(res);
        m_data = res;
        if (in_mode <= 2'd1) begin
          m_z = (res == 16'h0000); m_n = res[15]; m_v = in_nib_ovfl[3];
        end else if (in_mode == 2'd3) begin
          m_z = (res == 16'h0000);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", {15'd0, out_valid}, {15'd0, (mq.size() != 0)});
    chk("out_data", out_data, m_data);
    chk("flags_nzv", {13'd0, flag_n, flag_z, flag_v}, {13'd0, m_n, m_z, m_v});
  endtask

  typedef struct {
    logic [15:0] sum;
    logic [3:0]  ovfl;
    logic [1:0]  mode;
    logic [15:0] exp;
    logic [2:0]  nzv;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [2:0]  saved_nzv;
    logic [15:0] saved_data;

    vt[0]  = '{16'h8000, 4'b1000, 2'd0, 16'h7FFF, 3'b001};
    vt[1]  = '{16'h0000, 4'b0000, 2'd0, 16'h0000, 3'b010};
    vt[2]  = '{16'h9A34, 4'b1100, 2'd2, 16'h7734, 3'b010};
    vt[3]  = '{16'hF000, 4'b0000, 2'd1, 16'hF000, 3'b100};
    vt[4]  = '{16'h7000, 4'b1000, 2'd1, 16'h8000, 3'b101};
    vt[5]  = '{16'h0000, 4'b0000, 2'd3, 16'h0000, 3'b111};
    vt[6]  = '{16'h0001, 4'b0000, 2'd3, 16'h0001, 3'b101};
    vt[7]  = '{16'h0000, 4'b0000, 2'd2, 16'h0000, 3'b101};
    vt[8]  = '{16'h7F8F, 4'b1111, 2'd2, 16'h8777, 3'b101};
    vt[9]  = '{16'h0001, 4'b1000, 2'd0, 16'h8000, 3'b101};
    vt[10] = '{16'h0000, 4'b0111, 2'd0, 16'h0000, 3'b010};
    vt[11] = '{16'h8000, 4'b1000, 2'd3, 16'h8000, 3'b000};

    m_data = 16'h0000; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in_sum = 16'h1234; in_nib_ovfl = 4'b0000;
    in_mode = 2'd0; flush = 1'b0; out_ready = 1'b1;

    // Reset held two cycles with a live input that must not be taken.
    tick();
    tick();
    chk("reset_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_data", out_data, 16'h0000);
    chk("reset_flags", {13'd0, flag_n, flag_z, flag_v}, 16'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_sum = vt[i].sum; in_nib_ovfl = vt[i].ovfl; in_mode = vt[i].mode;
      tick();
      chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
      chk($sformatf("vec%0d_nzv", i), {13'd0, flag_n, flag_z, flag_v}, {13'd0, vt[i].nzv});
      chk($sformatf("vec%0d_valid", i), {15'd0, out_valid}, 16'd1);
    end

    // Backpressure: one result held while upstream keeps offering.
    out_ready = 1'b0;
    in_sum = 16'h1111; in_nib_ovfl = 4'b0000; in_mode = 2'd0;
    tick();
    saved_data = out_data;
    saved_nzv = {flag_n, flag_z, flag_v};
    for (int i = 0; i < 3; i++) begin
      in_sum = 16'h2000 + 16'(i); in_mode = 2'd1;
      tick();
      chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
      chk("stall_data", out_data, saved_data);
      chk("stall_flags", {13'd0, flag_n, flag_z, flag_v}, {13'd0, saved_nzv});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sum = 16'h3000 + 16'(i);
      tick();
      chk("drain_data", out_data, 16'h3000 + 16'(i));
    end

    // Flush with a held result and a same-cycle input.
    out_ready = 1'b0; in_sum = 16'h0000; in_mode = 2'd0;
    tick();
    saved_nzv = {flag_n, flag_z, flag_v};
    in_sum = 16'h8000; in_nib_ovfl = 4'b1000; in_mode = 2'd0; flush = 1'b1;
    tick();
    chk("flush_valid", {15'd0, out_valid}, 16'd0);
    chk("flush_flags", {13'd0, flag_n, flag_z, flag_v}, {13'd0, saved_nzv});
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Reset arriving mid-stall discards the held result.
    in_valid = 1'b1; out_ready = 1'b0; in_sum = 16'hF00F; in_nib_ovfl = 4'b0000; in_mode = 2'd0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_stall_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_stall_data", out_data, 16'h0000);
    rst = 1'b0;

    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(63) == 0);
      flush       = ($urandom_range(9) == 0);
      in_valid    = ($urandom_range(3) != 0);
      out_ready   = ($urandom_range(2) != 0);
      in_sum      = 16'($urandom);
      in_nib_ovfl = 4'($urandom);
      in_mode     = 2'($urandom);
      if ($urandom_range(7) == 0) in_sum = 16'h0000;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
